// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - system-register and exception-unit handshake bundle for irq_ctrl
//
// Signals:
//   sr_addr   system-register address (shared bus)
//   sr_wen    system-register write strobe
//   sr_wdata  system-register write data
//   irq       interrupt request to the exception unit
//   irq_id    id of the best eligible source, 0 when irq=0
//   irq_taken exception unit accepted an IRQ exception this cycle
//   eret      exception return committed this cycle
//
// The read-data net is tri-stated on the shared bus.
// It is therefore a plain port of irq_ctrl rather than a member of this bundle.
//
// Modports:
//   master  CPU / exception-unit side
//   slave   interrupt controller side

interface irq_ctrl_if;
    logic [15:0] sr_addr;
    logic        sr_wen;
    logic [31:0] sr_wdata;
    logic        irq;
    logic [4:0]  irq_id;
    logic        irq_taken;
    logic        eret;

    modport master (
        output sr_addr,
        output sr_wen,
        output sr_wdata,
        output irq_taken,
        output eret,
        input  irq,
        input  irq_id
    );

    modport slave (
        input  sr_addr,
        input  sr_wen,
        input  sr_wdata,
        input  irq_taken,
        input  eret,
        output irq,
        output irq_id
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - NSRC-source priority interrupt controller with one level of nesting
//
// Merges NSRC external interrupt sources into a single irq line.
// The lowest index has the highest priority.
// It tracks the in-service source plus one saved level, mirroring the exception unit's
// single saved-IE slot.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   src       raw interrupt source lines [NSRC-1:0]
//   bus       irq_ctrl_if.slave: sr_addr/sr_wen/sr_wdata, irq/irq_id, irq_taken/eret
//   sr_rdata  register read data; 'z outside SR_BASE..SR_BASE+3
//
// Register map (relative to SR_BASE):
//   +0 PEND   read pending bits; write-1-to-clear on edge-configured bits only
//   +1 EN     read/write enable mask
//   +2 EDGE   read/write, 1 = edge-triggered, 0 = level
//   +3 CLAIM  read-only {svc_valid, 26'b0, svc_id}
//
// Optional build macro:
//   IRQ_CTRL_SYNC_EN  inserts a 2-flop synchronizer ahead of src_q,
//                     adding two cycles to every src-to-irq latency

module irq_ctrl #(
    parameter int          NSRC    = 8,
    parameter logic [15:0] SR_BASE = 16'h0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    irq_ctrl_if.slave         bus,
    output wire  [31:0]       sr_rdata
);

    localparam logic [15:0] A_PEND  = SR_BASE;
    localparam logic [15:0] A_EN    = SR_BASE + 16'd1;
    localparam logic [15:0] A_EDGE  = SR_BASE + 16'd2;
    localparam logic [15:0] A_CLAIM = SR_BASE + 16'd3;

    logic [NSRC-1:0] src_s;     // source as seen by the edge/level logic
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] en;
    logic [NSRC-1:0] edge_cfg;

    logic            svc_valid;
    logic [4:0]      svc_id;
    logic            saved_valid;
    logic [4:0]      saved_id;

    logic [NSRC-1:0] elig;
    logic [4:0]      best;
    logic            irq_int;
    logic            take;
    logic [NSRC-1:0] take_mask;
    logic [NSRC-1:0] w1c_mask;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] pend_next;

    logic            wr_pend;
    logic            wr_en;
    logic            wr_edge;

    logic [31:0]     rd_data;
    logic            rd_hit;

    // Write-data bits above NSRC have no storage behind them.
    wire unused_wdata = &{1'b0, bus.sr_wdata[31:NSRC]};

`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = src;
`endif

    // Register write decode
    assign wr_pend = bus.sr_wen && (bus.sr_addr == A_PEND);
    assign wr_en   = bus.sr_wen && (bus.sr_addr == A_EN);
    assign wr_edge = bus.sr_wen && (bus.sr_addr == A_EDGE);

    // Priority select
    // irq depends only on registered state, so src never reaches irq combinationally.
    always_comb begin
        elig = pend & en;
        best = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                best = 5'(i);
            end
        end
        irq_int = (elig != '0) && (!svc_valid || (best < svc_id));
    end

    assign bus.irq    = irq_int;
    assign bus.irq_id = irq_int ? best : 5'd0;

    // Accept signal
    // A take is honoured only when an irq is actually presented.
    // A simultaneous eret always wins over the take.
    assign take = bus.irq_taken && irq_int && !bus.eret;

    always_comb begin
        take_mask = '0;
        if (take) begin
            take_mask[best] = 1'b1;
        end
    end

    // Pending update
    // Edge bits clear on W1C or on a take, and a same-cycle set wins over the clear.
    // Level bits follow src_q, which gives them one more cycle of latency than edge bits.
    assign w1c_mask = wr_pend ? bus.sr_wdata[NSRC-1:0] : '0;
    assign edge_set = src_s & ~src_q;

    always_comb begin
        pend_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (edge_cfg[i]) begin
                pend_next[i] = (pend[i] & ~(w1c_mask[i] | take_mask[i])) | edge_set[i];
            end else begin
                pend_next[i] = src_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            pend     <= '0;
            en       <= '0;
            edge_cfg <= '0;
        end else begin
            src_q <= src_s;
            pend  <= pend_next;
            if (wr_en) begin
                en <= bus.sr_wdata[NSRC-1:0];
            end
            if (wr_edge) begin
                edge_cfg <= bus.sr_wdata[NSRC-1:0];
            end
        end
    end

    // In-service tracking
    // eret restores the saved slot and empties it completely.
    // An emptied slot therefore never leaks a stale id into CLAIM.
    always_ff @(posedge clk) begin
        if (rst) begin
            svc_valid   <= 1'b0;
            svc_id      <= 5'd0;
            saved_valid <= 1'b0;
            saved_id    <= 5'd0;
        end else if (bus.eret) begin
            svc_valid   <= saved_valid;
            svc_id      <= saved_id;
            saved_valid <= 1'b0;
            saved_id    <= 5'd0;
        end else if (take) begin
            saved_valid <= svc_valid;
            saved_id    <= svc_id;
            svc_valid   <= 1'b1;
            svc_id      <= best;
        end
    end

    // Read mux
    // The read data drives the shared bus only for addresses this block owns.
    always_comb begin
        rd_data = 32'd0;
        rd_hit  = 1'b1;
        case (bus.sr_addr)
            A_PEND:  rd_data = {{(32-NSRC){1'b0}}, pend};
            A_EN:    rd_data = {{(32-NSRC){1'b0}}, en};
            A_EDGE:  rd_data = {{(32-NSRC){1'b0}}, edge_cfg};
            A_CLAIM: rd_data = {svc_valid, 26'd0, svc_id};
            default: rd_hit  = 1'b0;
        endcase
    end

    assign sr_rdata = rd_hit ? rd_data : 32'bz;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl

module tb_irq_ctrl;
    localparam int          NSRC    = 8;
    localparam logic [15:0] SR_BASE = 16'h0010;
    localparam logic [15:0] A_PEND  = SR_BASE;
    localparam logic [15:0] A_EN    = SR_BASE + 16'd1;
    localparam logic [15:0] A_EDGE  = SR_BASE + 16'd2;
    localparam logic [15:0] A_CLAIM = SR_BASE + 16'd3;

    logic            clk;
    logic            rst;
    logic [NSRC-1:0] src;
    wire  [31:0]     sr_rdata;

    int tests_run;
    int tests_failed;

    irq_ctrl_if bus ();

    irq_ctrl #(.NSRC(NSRC), .SR_BASE(SR_BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .bus      (bus.slave),
        .sr_rdata (sr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sr_write(input logic [15:0] a, input logic [31:0] d);
        bus.sr_addr  = a;
        bus.sr_wdata = d;
        bus.sr_wen   = 1'b1;
        step();
        bus.sr_wen   = 1'b0;
        bus.sr_addr  = 16'h0000;
    endtask

    task automatic sr_read(input logic [15:0] a, output logic [31:0] d);
        bus.sr_addr = a;
        #1;
        d = sr_rdata;
        bus.sr_addr = 16'h0000;
    endtask

    task automatic take_irq();
        bus.irq_taken = 1'b1;
        step();
        bus.irq_taken = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        step();
        bus.eret = 1'b0;
    endtask

    task automatic check_irq(input string tag, input logic exp_irq, input logic [4:0] exp_id);
        check({tag, "_irq"}, 32'(bus.irq), 32'(exp_irq));
        check({tag, "_id"}, 32'(bus.irq_id), 32'(exp_id));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        src           = '0;
        bus.sr_addr   = 16'h0000;
        bus.sr_wen    = 1'b0;
        bus.sr_wdata  = 32'd0;
        bus.irq_taken = 1'b0;
        bus.eret      = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_irq("reset", 1'b0, 5'd0);
        sr_read(A_PEND, d);  check("reset_pend", d, 32'h0);
        sr_read(A_CLAIM, d); check("reset_claim", d, 32'h0);

        // 1: level sources with priority
        sr_write(A_EN, 32'h05);
        src = 8'h04;
        step();
        check_irq("t1_lat", 1'b0, 5'd0);
        step();
        check_irq("t1_src2", 1'b1, 5'd2);
        src = 8'h05;
        step();
        check_irq("t1_src0_lag", 1'b1, 5'd2);
        step();
        check_irq("t1_src0", 1'b1, 5'd0);
        src = 8'h00;
        step();
        step();
        check_irq("t1_idle", 1'b0, 5'd0);

        // 2: edge source, W1C, set-wins
        sr_write(A_EN, 32'h01);
        sr_write(A_EDGE, 32'h01);
        src = 8'h01;
        step();
        src = 8'h00;
        check_irq("t2_edge", 1'b1, 5'd0);
        sr_read(A_PEND, d); check("t2_pend_set", d, 32'h1);
        step();
        sr_read(A_PEND, d); check("t2_pend_hold", d, 32'h1);
        sr_write(A_PEND, 32'h1);
        sr_read(A_PEND, d); check("t2_w1c", d, 32'h0);
        check_irq("t2_w1c", 1'b0, 5'd0);
        src = 8'h01;
        sr_write(A_PEND, 32'h1);
        src = 8'h00;
        sr_read(A_PEND, d); check("t2_set_wins", d, 32'h1);
        sr_write(A_PEND, 32'h1);
        sr_read(A_PEND, d); check("t2_clear", d, 32'h0);

        // 3: nesting
        sr_write(A_EDGE, 32'h00);
        sr_write(A_EN, 32'h0A);
        src = 8'h08;
        step();
        step();
        check_irq("t3_src3", 1'b1, 5'd3);
        take_irq();
        sr_read(A_CLAIM, d); check("t3_claim3", d, 32'h8000_0003);
        check_irq("t3_masked", 1'b0, 5'd0);
        src = 8'h0A;
        step();
        step();
        check_irq("t3_nest", 1'b1, 5'd1);
        take_irq();
        sr_read(A_CLAIM, d); check("t3_claim1", d, 32'h8000_0001);
        check_irq("t3_masked1", 1'b0, 5'd0);
        do_eret();
        sr_read(A_CLAIM, d); check("t3_eret1", d, 32'h8000_0003);
        check_irq("t3_after_eret1", 1'b1, 5'd1);
        do_eret();
        sr_read(A_CLAIM, d); check("t3_eret2", d, 32'h0);
        src = 8'h00;
        step();
        step();
        check_irq("t3_idle", 1'b0, 5'd0);

        // 4: lower priority held off until eret
        sr_write(A_EN, 32'h22);
        src = 8'h02;
        step();
        step();
        take_irq();
        src = 8'h20;
        step();
        step();
        check_irq("t4_blocked", 1'b0, 5'd0);
        sr_read(A_CLAIM, d); check("t4_claim", d, 32'h8000_0001);
        do_eret();
        check_irq("t4_released", 1'b1, 5'd5);
        src = 8'h00;
        step();
        step();

        // 5: decode and register widths
        sr_write(A_EN, 32'hFFFF_FFFF);
        sr_read(A_EN, d); check("t5_en_width", d, 32'h0000_00FF);
        sr_read(SR_BASE + 16'd4, d);
        check("t5_unmapped", 32'((d === 32'bz) || (d === 32'h0)), 32'd1);
        sr_write(A_CLAIM, 32'hFFFF_FFFF);
        sr_read(A_CLAIM, d); check("t5_claim_ro", d, 32'h0);
        sr_write(A_EDGE, 32'hFFFF_FF00);
        sr_read(A_EDGE, d); check("t5_edge_width", d, 32'h0);

        // 6: reset mid-service
        src = 8'hFF;
        step();
        step();
        sr_read(A_PEND, d); check("t6_pend_ff", d, 32'h0000_00FF);
        take_irq();
        sr_read(A_CLAIM, d); check("t6_claim0", d, 32'h8000_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_irq("t6_reset", 1'b0, 5'd0);
        sr_read(A_CLAIM, d); check("t6_claim", d, 32'h0);
        sr_read(A_PEND, d);  check("t6_pend", d, 32'h0);
        sr_read(A_EN, d);    check("t6_en", d, 32'h0);
        src = 8'h00;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
